// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: two-requester round-robin arbiter feeding a one-entry registered 2:1 mux output
module rr_mux_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sel,
  input  logic                  out_ready
);
  logic                  out_valid_q, out_sel_q, last_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  load_en, grant_v, grant_b;
  always_comb begin
    load_en = !out_valid_q || out_ready;
    grant_v = !reset && load_en && (a_valid || b_valid);
    grant_b = b_valid && (!a_valid || !last_q);
    a_ready = grant_v && !grant_b;
    b_ready = grant_v && grant_b;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 1'b0;
      last_q      <= 1'b1;
    end else if (grant_v) begin
      out_valid_q <= 1'b1;
      out_data_q  <= grant_b ? b_data : a_data;
      out_sel_q   <= grant_b;
      last_q      <= grant_b;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed plan checks plus randomized traffic against a behavioural model
module tb_rr_mux_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, out_valid, out_sel;
  logic [7:0] out_data;
  int         checks = 0, errors = 0;
  logic       chk_en = 1'b0;
  logic       m_v = 1'b0, m_s = 1'b0, m_last = 1'b1;
  logic [7:0] m_d = '0;

  rr_mux_arbiter #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  // Who should be served this cycle: -1 none, 0 = A, 1 = B.
  function automatic int pick();
    if (reset) return -1;
    if (m_v && !out_ready) return -1;
    if (a_valid && b_valid) return m_last ? 0 : 1;
    if (a_valid) return 0;
    if (b_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = pick();
    if (reset) begin
      m_v = 1'b0; m_d = '0; m_s = 1'b0; m_last = 1'b1;
    end else if (g >= 0) begin
      m_v = 1'b1; m_d = (g == 1) ? b_data : a_data; m_s = (g == 1); m_last = (g == 1);
    end else if (out_ready) begin
      m_v = 1'b0;
    end
  end

  always @(negedge clk) begin
    int g;
    if (chk_en) begin
      g = pick();
      chk("model a_ready", {31'd0, a_ready}, {31'd0, g == 0});
      chk("model b_ready", {31'd0, b_ready}, {31'd0, g == 1});
      chk("model out_valid", {31'd0, out_valid}, {31'd0, m_v});
      chk("model out_sel", {31'd0, out_sel}, {31'd0, m_s});
      chk("model out_data", {24'd0, out_data}, {24'd0, m_d});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [7:0] ad, input logic bv, input logic [7:0] bd, input logic ordy);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
    #1;
  endtask

  task automatic out_is(input string n, input logic v, input logic [7:0] d, input logic s);
    chk({n, " valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({n, " data"}, {24'd0, out_data}, {24'd0, d});
    chk({n, " sel"}, {31'd0, out_sel}, {31'd0, s});
  endtask

  task automatic rdy_is(input string n, input logic ar, input logic br);
    chk({n, " a_ready"}, {31'd0, a_ready}, {31'd0, ar});
    chk({n, " b_ready"}, {31'd0, b_ready}, {31'd0, br});
  endtask

  initial begin
    logic [7:0] seq_a [3];
    logic       a_fire, b_fire;
    seq_a = '{8'h11, 8'h22, 8'h33};
    // reset held two cycles with both requesting
    drive(1, 8'h12, 1, 8'h34, 1);
    tick();
    chk_en = 1'b1;
    rdy_is("reset", 0, 0);
    tick();
    rdy_is("reset", 0, 0);
    drive(0, 0, 0, 0, 1);
    reset = 1'b0;
    #1;
    out_is("after reset", 0, 8'h00, 0);
    // A alone streams three words
    for (int i = 0; i < 3; i++) begin
      drive(1, seq_a[i], 0, 0, 1);
      rdy_is("a only", 1, 0);
      tick();
      out_is("a only", 1, seq_a[i], 0);
    end
    // tie alternation straight after reset
    reset = 1'b1;
    drive(0, 0, 0, 0, 1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'hAA, 1, 8'hBB, 1);
      rdy_is("tie", i % 2 == 0, i % 2 == 1);
      tick();
      out_is("tie", 1, (i % 2 == 0) ? 8'hAA : 8'hBB, i % 2 == 1);
    end
    // backpressure on a held 0x5C
    drive(1, 8'h5C, 0, 0, 1);
    tick();
    out_is("bp load", 1, 8'h5C, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h66, 1, 8'h77, 0);
      rdy_is("bp hold", 0, 0);
      tick();
      out_is("bp hold", 1, 8'h5C, 0);
    end
    drive(1, 8'h66, 1, 8'h77, 1);
    rdy_is("bp release", 0, 1);
    tick();
    out_is("bp release", 1, 8'h77, 1);
    // lone B grant moves the pointer so A wins the next tie
    drive(0, 0, 1, 8'h01, 1);
    tick();
    out_is("lone b", 1, 8'h01, 1);
    drive(1, 8'h21, 1, 8'h42, 1);
    tick();
    out_is("ptr a", 1, 8'h21, 0);
    drive(1, 8'h23, 1, 8'h42, 1);
    tick();
    out_is("ptr b", 1, 8'h42, 1);
    // reset while a word is stalled
    drive(1, 8'h99, 0, 0, 1);
    tick();
    out_is("pre reset", 1, 8'h99, 0);
    drive(1, 8'h98, 1, 8'h97, 0);
    reset = 1'b1;
    #1;
    rdy_is("mid reset", 0, 0);
    tick();
    out_is("mid reset", 0, 8'h00, 0);
    reset = 1'b0;
    drive(1, 8'hA1, 1, 8'hB2, 1);
    tick();
    out_is("first tie", 1, 8'hA1, 0);
    // randomized traffic; requesters hold valid/data until accepted
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      a_fire = a_valid && a_ready;
      b_fire = b_valid && b_ready;
      tick();
      if (!a_valid || a_fire) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_data = 8'($urandom);
      end
      if (!b_valid || b_fire) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_data = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      #1;
    end
    reset = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Two-requester round-robin arbiter wrapped around the 2:1 data mux. Each requester offers a DATA_WIDTH word with a valid/ready handshake. The block grants one requester per cycle, steers its data through the mux select and holds it in a one-entry output register with its own valid/ready handshake. It sits in front of any shared single-port consumer that the mux feeds, and guarantees alternating service when both sides request continuously.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each data word.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a_valid  input  1  requester A offers a_data.
- a_data  input  DATA_WIDTH  requester A word.
- a_ready  output  1  A's word is accepted this cycle.
- b_valid  input  1  requester B offers b_data.
- b_data  input  DATA_WIDTH  requester B word.
- b_ready  output  1  B's word is accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  DATA_WIDTH  held word.
- out_sel  output  1  source of the held word: 0 = A, 1 = B.
- out_ready  input  1  consumer accepts out_data this cycle.

## Operation
- State:
  - output register (out_valid, out_data, out_sel);
  - priority pointer last_grant (0 = A granted last, 1 = B granted last).
- load_en = !out_valid || out_ready. The register may accept a new word when it is empty or is being drained in the same cycle.
- Grant, evaluated only when load_en = 1:
  - only a_valid → grant A;
  - only b_valid → grant B;
  - both valid → grant the side not equal to last_grant;
  - neither valid → no grant.
- Handshakes:
  - a_ready = load_en && grant == A.
  - b_ready = load_en && grant == B.
  - At most one ready is high in any cycle.
  - Neither ready is asserted when load_en = 0.
- Mux: the select is the grant. The granted word is captured into out_data, and out_sel is set to the grant.
- Register update per cycle:
  - grant → out_valid=1, out_data/out_sel loaded, last_grant = grant.
  - no grant and out_ready=1 → out_valid=0. out_data/out_sel keep their last value.
  - out_valid=1 and out_ready=0 → everything holds.
- last_grant changes only on an accepted transfer. Lone requests update it too, so fairness is relative to the last actual grant.
- Requesters hold valid and data stable until they see ready; the block does not buffer unaccepted words.
- Arithmetic: no width conversion. out_data is exactly the selected input word.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, last_grant=1 (A wins the first tie). a_ready and b_ready are 0 while reset is high.
- a_ready and b_ready are combinational from a_valid, b_valid, out_valid, out_ready and last_grant.
- out_* are registered.
- Latency: a word accepted at edge N is visible on out_data with out_valid=1 after edge N. The consumer can take it in the following cycle.
- Throughput: one word per cycle while out_ready=1 and any request is pending. Both requesters pending → strict A,B,A,B alternation.
- Backpressure: out_valid=1 and out_ready=0 → out_data and out_sel stable, both readies 0.
- Simultaneous drain and load: the new word replaces the drained one at the same edge, with no bubble.
- Reset mid-operation: a held word is discarded, all state returns to reset values the next cycle, and any in-flight request is not acknowledged.

## Test plan
- Reset check: hold reset 2 cycles with a_valid=b_valid=1 → a_ready=b_ready=0. After the release edge, out_valid=0, out_data=0x00, out_sel=0.
- A only: A streams 0x11,0x22,0x33 with out_ready=1 → a_ready high every cycle. out_data reads 0x11,0x22,0x33 on consecutive cycles, out_sel=0, b_ready=0.
- Tie alternation: both valid continuously (A=0xAA, B=0xBB), out_ready=1, for 6 cycles after reset → outputs AA,BB,AA,BB,AA,BB with out_sel 0,1,0,1,0,1.
- Backpressure: out_valid=1 with out_data=0x5C, drop out_ready for 3 cycles with both valid → out_data=0x5C and out_sel stable, a_ready=b_ready=0. On out_ready=1, the next word loads in the same cycle.
- Pointer after lone grant: B alone sends 0x01, then both valid → A granted next (out_data=A's word), then B.
- Reset mid-stream: assert reset while out_valid=1 and out_ready=0 → the next cycle shows out_valid=0 and out_data=0x00. The first tie after release goes to A.
